// File: rtl/raster_row_packer_pkg.sv
// raster_pkg: types shared by the rasteriser blocks (pixel scanner,
// triangle test, row packer).
//   COORD_W  width of row/column coordinates
//   coord_t  coordinate type
//   IDX_W    width of the per-row word index
//   state_t  row packer sequencing states
package raster_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned IDX_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    S_SYNC = 1'b0,
    S_PACK = 1'b1
  } state_t;

endpackage

// File: rtl/raster_row_packer_if.sv
// raster_row_packer_if: pixel input stream and packed-word output stream
// of the row packer.
//   in_valid/in_ready                   pixel handshake
//   in_linha/in_coluna/in_dentro        pixel row, column, inside flag
//   out_valid/out_ready                 packed word handshake
//   out_data                            packed flags, bit i = column idx*WORD_W+i
//   out_linha/out_word_idx              row and word index of the word
//   out_last/out_frame_end              last word of row / of row 0
// Modports: slave = packer side, master = pixel source + word sink side.
interface raster_row_packer_if #(
  parameter int unsigned WORD_W = 16
);
  import raster_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  coord_t               in_linha;
  coord_t               in_coluna;
  logic                 in_dentro;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_data;
  coord_t               out_linha;
  logic [IDX_W-1:0]     out_word_idx;
  logic                 out_last;
  logic                 out_frame_end;

  modport slave (
    input  in_valid, in_linha, in_coluna, in_dentro, out_ready,
    output in_ready, out_valid, out_data, out_linha, out_word_idx,
           out_last, out_frame_end
  );

  modport master (
    output in_valid, in_linha, in_coluna, in_dentro, out_ready,
    input  in_ready, out_valid, out_data, out_linha, out_word_idx,
           out_last, out_frame_end
  );

endinterface

// File: rtl/raster_row_packer_accum.sv
// raster_bit_accum: WORD_W-bit flag accumulator with bit counter.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load, i_bit   place i_bit at the current bit position and advance
//   i_flush         clear accumulator and counter (wins over i_load)
//   o_word          accumulator including the bit being loaded this cycle
//   o_full          current bit position is the last of the word
module raster_bit_accum #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_bit,
  input  logic              i_flush,
  output logic [WORD_W-1:0] o_word,
  output logic              o_full
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] w_ins;

  // o_word already contains the incoming bit so a completing pixel can be
  // registered into the output stage in the same cycle it is accepted.
  always_comb begin
    w_ins        = '0;
    w_ins[r_cnt] = i_load & i_bit;
    o_word       = r_acc | w_ins;
    o_full       = (r_cnt == CNT_W'(WORD_W - 1));
  end

  // Cleared bits after a flush give the zero fill of a partial last word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= o_word;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/raster_row_packer.sv
// raster_row_packer: sink of the rasteriser pixel stream. Checks scan
// order (rows ROWS-1 down to 0, columns 0..COLS-1), packs each row's
// dentro flags into WORD_W-bit words and emits them with row/word tags.
//   Clock, Reset_n  clock, asynchronous active-low reset
//   bus             raster_row_packer_if.slave (pixel in, word out)
//   err_seq         sticky scan-order error, cleared only by reset
//   out_row_count   (RASTER_PACK_COUNT_EN only) dentro=1 count of the
//                   row, valid with out_last, 0 on other words
// Optional feature macro: RASTER_PACK_COUNT_EN.
module raster_row_packer
  import raster_pkg::*;
#(
  parameter int unsigned COLS   = 41,
  parameter int unsigned ROWS   = 51,
  parameter int unsigned WORD_W = 16
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  raster_row_packer_if.slave      bus,
`ifdef RASTER_PACK_COUNT_EN
  output coord_t                  out_row_count,
`endif
  output logic                    err_seq
);

  localparam coord_t LAST_COL = coord_t'(COLS - 1);
  localparam coord_t TOP_ROW  = coord_t'(ROWS - 1);

  state_t            r_state, w_state_nxt;
  coord_t            r_exp_row, w_exp_row_nxt;
  coord_t            r_exp_col, w_exp_col_nxt;
  logic [IDX_W-1:0]  r_word_idx, w_word_idx_nxt;
  logic              r_err_seq;

  logic              w_take, w_match, w_load, w_flush, w_err_set;
  logic              w_complete, w_row_end;
  logic [WORD_W-1:0] w_acc_word;
  logic              w_acc_full;

  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  coord_t            r_out_linha;
  logic [IDX_W-1:0]  r_out_word_idx;
  logic              r_out_last;
  logic              r_out_frame_end;

  // A new pixel is only taken when the output slot is free or being freed,
  // so a completing pixel can always load the output register.
  assign bus.in_ready = !(r_out_valid && !bus.out_ready);
  assign w_take       = bus.in_valid && bus.in_ready;
  // exp_col is held at 0 while in S_SYNC, so one compare serves both states.
  assign w_match      = (bus.in_linha == r_exp_row) && (bus.in_coluna == r_exp_col);

  raster_bit_accum #(
    .WORD_W (WORD_W)
  ) u_accum (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_load  (w_load),
    .i_bit   (bus.in_dentro),
    .i_flush (w_flush),
    .o_word  (w_acc_word),
    .o_full  (w_acc_full)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_SYNC;
      r_exp_row  <= TOP_ROW;
      r_exp_col  <= '0;
      r_word_idx <= '0;
      r_err_seq  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp_row  <= w_exp_row_nxt;
      r_exp_col  <= w_exp_col_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_err_seq  <= r_err_seq | w_err_set;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_exp_row_nxt  = r_exp_row;
    w_exp_col_nxt  = r_exp_col;
    w_word_idx_nxt = r_word_idx;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    w_err_set      = 1'b0;
    w_complete     = 1'b0;
    w_row_end      = 1'b0;

    unique case (r_state)
      S_SYNC: begin
        if (w_take) begin
          if (w_match) begin
            w_load      = 1'b1;
            w_state_nxt = S_PACK;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_PACK: begin
        if (w_take) begin
          if (w_match) begin
            w_load = 1'b1;
          end else begin
            w_err_set      = 1'b1;
            w_flush        = 1'b1;
            w_state_nxt    = S_SYNC;
            w_exp_col_nxt  = '0;
            w_word_idx_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase

    if (w_load) begin
      w_row_end  = (bus.in_coluna == LAST_COL);
      w_complete = w_acc_full || w_row_end;
      w_flush    = w_complete;
      if (w_row_end) begin
        w_exp_col_nxt  = '0;
        w_word_idx_nxt = '0;
        w_exp_row_nxt  = (r_exp_row == '0) ? TOP_ROW : r_exp_row - coord_t'(1);
      end else begin
        w_exp_col_nxt = r_exp_col + coord_t'(1);
        if (w_complete) begin
          w_word_idx_nxt = r_word_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_linha     <= '0;
      r_out_word_idx  <= '0;
      r_out_last      <= 1'b0;
      r_out_frame_end <= 1'b0;
    end else if (w_complete) begin
      r_out_valid     <= 1'b1;
      r_out_data      <= w_acc_word;
      r_out_linha     <= r_exp_row;
      r_out_word_idx  <= r_word_idx;
      r_out_last      <= w_row_end;
      r_out_frame_end <= w_row_end && (r_exp_row == '0);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RASTER_PACK_COUNT_EN
  coord_t r_row_cnt;
  coord_t r_out_row_count;
  coord_t w_cnt_sum;

  // Column 0 restarts the count regardless of what is left in r_row_cnt.
  assign w_cnt_sum = ((bus.in_coluna == '0) ? '0 : r_row_cnt) + coord_t'(bus.in_dentro);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_row_cnt       <= '0;
      r_out_row_count <= '0;
    end else begin
      if (w_err_set) begin
        r_row_cnt <= '0;
      end else if (w_load) begin
        r_row_cnt <= w_row_end ? '0 : w_cnt_sum;
      end
      if (w_complete) begin
        r_out_row_count <= w_row_end ? w_cnt_sum : '0;
      end
    end
  end

  assign out_row_count = r_out_row_count;
`endif

  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_linha     = r_out_linha;
  assign bus.out_word_idx  = r_out_word_idx;
  assign bus.out_last      = r_out_last;
  assign bus.out_frame_end = r_out_frame_end;
  assign err_seq           = r_err_seq;

endmodule
